// File: rtl/demux_rr_pkg.sv
// demux_rr_pkg: shared types, sizes and the rotate-priority pick for the round-robin demux scheduler.
package demux_rr_pkg;
    localparam int NUM_CH = 4;
    localparam int SEL_W = 2;
    typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;
    // Scan from the farthest offset down so the nearest enabled channel to base wins.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_CH-1:0] mask, input logic [SEL_W-1:0] base);
        logic [SEL_W-1:0] k;
        rr_pick = base;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            k = base + SEL_W'(i);
            if (mask[k]) rr_pick = k;
        end
    endfunction
endpackage

// File: rtl/demux_rr_scheduler_rr_pick4.sv
// rr_pick4: combinational 4-way rotate-priority encoder, first enabled channel at or after base.
module rr_pick4
    import demux_rr_pkg::*;
(
    input  logic [NUM_CH-1:0] mask_i,
    input  logic [SEL_W-1:0]  base_i,
    output logic [SEL_W-1:0]  target_o
);
    assign target_o = rr_pick(mask_i, base_i);
endmodule

// File: rtl/demux_rr_scheduler.sv
// demux_rr_scheduler: single-entry beat buffer steering each beat round-robin to one of 4 enabled lanes.
// Define DEMUX_RR_SCHED_CNT_EN to add per-channel delivered-beat counters on o_ch_cnt.
module demux_rr_scheduler
    import demux_rr_pkg::*;
#(
    parameter int DATA_W = 8
`ifdef DEMUX_RR_SCHED_CNT_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NUM_CH-1:0] i_ch_en,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [SEL_W-1:0]  o_sel,
    output logic [NUM_CH-1:0] o_ch_valid,
    input  logic [NUM_CH-1:0] i_ch_ready
`ifdef DEMUX_RR_SCHED_CNT_EN
    , output logic [NUM_CH*CNT_W-1:0] o_ch_cnt
`endif
);
    state_t state_q;
    logic [DATA_W-1:0] data_q;
    logic [SEL_W-1:0] sel_q, sel_d, rr_q, base;
    logic [NUM_CH-1:0] ch_valid_q;
    logic deliver, accept, ready;

    assign deliver = state_q == ST_FULL && i_ch_ready[sel_q];
    // Gating with reset keeps the producer stalled for the whole reset window.
    assign ready = !i_rst && |i_ch_en && (state_q == ST_EMPTY || deliver);
    assign accept = i_valid && ready;
    assign base = deliver ? sel_q + SEL_W'(1) : rr_q;

    rr_pick4 u_pick (
        .mask_i  (i_ch_en),
        .base_i  (base),
        .target_o(sel_d)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_EMPTY;
            data_q     <= '0;
            sel_q      <= '0;
            rr_q       <= '0;
            ch_valid_q <= '0;
        end else begin
            if (deliver) rr_q <= sel_q + SEL_W'(1);
            if (accept) begin
                state_q    <= ST_FULL;
                data_q     <= i_data;
                sel_q      <= sel_d;
                ch_valid_q <= NUM_CH'(1) << sel_d;
            end else if (deliver) begin
                state_q    <= ST_EMPTY;
                ch_valid_q <= '0;
            end
        end
    end

    assign o_ready    = ready;
    assign o_data     = data_q;
    assign o_sel      = sel_q;
    assign o_ch_valid = ch_valid_q;

`ifdef DEMUX_RR_SCHED_CNT_EN
    logic [NUM_CH*CNT_W-1:0] cnt_q;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) cnt_q <= '0;
        else if (deliver) cnt_q[sel_q*CNT_W +: CNT_W] <= cnt_q[sel_q*CNT_W +: CNT_W] + CNT_W'(1);
    end
    assign o_ch_cnt = cnt_q;
`endif
endmodule
